// File: rtl/group_update_sequencer.sv
// Purpose: walks the group code 0..NUM_GROUPS-1 into the update-order LUT and strobes each group after a settle window.
// Latency: start sampled at edge k gives group 0 live from cycle k+1; each group lasts SETTLE_CYCLES+1 cycles.
// Backpressure: none; stop is sticky and honoured only at a sweep boundary, start/num_sweeps ignored while busy.
module group_update_sequencer #(
  parameter int NUM_GROUPS    = 3,
  parameter int GROUP_W       = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int SWEEP_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic [GROUP_W-1:0] group_EN,
  output logic               group_valid,
  output logic               update_strobe,
  output logic               sweep_done,
  output logic               run_done,
  output logic               busy,
  output logic [SWEEP_W-1:0] sweep_count
);

  localparam int DWELL_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_INIT = DWELL_W'(SETTLE_CYCLES - 1);
  localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [GROUP_W-1:0]   group_q, group_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [SWEEP_W-1:0]   target_q, target_d;
  logic [SWEEP_W-1:0]   count_q, count_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 run_active_d;
  logic                 last_sweep;

  // Run ends after the last group when the programmed count is reached or a stop is (or was) requested.
  assign last_sweep = ((target_q != '0) && ((count_q + SWEEP_W'(1)) == target_q))
                      || stop_pend_q || stop;

  // Next-state, group, dwell and sweep bookkeeping.
  always_comb begin
    state_d     = state_q;
    group_d     = group_q;
    dwell_d     = dwell_q;
    target_d    = target_q;
    count_d     = count_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          target_d = num_sweeps;
          count_d  = '0;
          group_d  = '0;
          dwell_d  = DWELL_INIT;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (stop) stop_pend_d = 1'b1;
        if (dwell_q == '0) begin
          state_d = UPDATE;
        end else begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
      end
      UPDATE: begin
        if (stop) stop_pend_d = 1'b1;
        if (group_q != LAST_GROUP) begin
          group_d = group_q + GROUP_W'(1);
          dwell_d = DWELL_INIT;
          state_d = SETTLE;
        end else begin
          count_d = count_q + SWEEP_W'(1);
          group_d = '0;
          if (last_sweep) begin
            state_d = DONE;
          end else begin
            dwell_d = DWELL_INIT;
            state_d = SETTLE;
          end
        end
      end
      DONE: begin
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign run_active_d = (state_d == SETTLE) || (state_d == UPDATE);

  // State register plus outputs registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      group_q       <= '0;
      dwell_q       <= '0;
      target_q      <= '0;
      count_q       <= '0;
      stop_pend_q   <= 1'b0;
      group_EN      <= '0;
      group_valid   <= 1'b0;
      update_strobe <= 1'b0;
      sweep_done    <= 1'b0;
      run_done      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      group_q       <= group_d;
      dwell_q       <= dwell_d;
      target_q      <= target_d;
      count_q       <= count_d;
      stop_pend_q   <= stop_pend_d;
      group_EN      <= run_active_d ? group_d : '0;
      group_valid   <= run_active_d;
      update_strobe <= (state_d == UPDATE);
      sweep_done    <= (state_d == UPDATE) && (group_d == LAST_GROUP);
      run_done      <= (state_d == DONE);
      busy          <= run_active_d;
    end
  end

  assign sweep_count = count_q;

endmodule

// File: tb/tb_group_update_sequencer.sv
module tb_group_update_sequencer;

  localparam int NG   = 3;
  localparam int SC   = 4;
  localparam int GPER = SC + 1;
  localparam int SPER = NG * GPER;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [15:0] num_sweeps;
  logic [2:0]  group_EN;
  logic        group_valid, update_strobe, sweep_done, run_done, busy;
  logic [15:0] sweep_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int off;
    int grp;
    bit sd;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  group_update_sequencer #(
    .NUM_GROUPS(NG), .GROUP_W(3), .SETTLE_CYCLES(SC), .SWEEP_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_sweeps(num_sweeps),
    .group_EN(group_EN), .group_valid(group_valid), .update_strobe(update_strobe),
    .sweep_done(sweep_done), .run_done(run_done), .busy(busy), .sweep_count(sweep_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_group_EN"}, group_EN, 0);
    chk({tag, "_group_valid"}, group_valid, 0);
    chk({tag, "_update_strobe"}, update_strobe, 0);
    chk({tag, "_sweep_done"}, sweep_done, 0);
    chk({tag, "_run_done"}, run_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sweep_count"}, sweep_count, 0);
  endtask

  // One run: start sampled at edge k; loop index n observes cycle k+n at the falling edge.
  task automatic run(input string name, input int nsw, input int stop_at,
                     input int poke_at, input bit idle_stop);
    int  s_exp;
    int  last;
    ev_t e;
    s_exp = nsw;
    if (stop_at > 0) begin
      int sc;
      sc = (stop_at - 1) / SPER + 1;
      if (nsw == 0 || sc < s_exp) s_exp = sc;
    end
    for (int s = 0; s < s_exp; s++)
      for (int g = 0; g < NG; g++) begin
        e.off = s * SPER + g * GPER + GPER;
        e.grp = g;
        e.sd  = (g == NG - 1);
        exp_q.push_back(e);
      end
    last = s_exp * SPER + 1;

    @(negedge clk);
    start      = 1'b1;
    num_sweeps = 16'(nsw);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= last + 4; n++) begin
      if (update_strobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk({name, "_extra_strobe"}, n, 0);
        end else begin
          e = exp_q.pop_front();
          chk({name, "_strobe_cycle"}, n, e.off);
          chk({name, "_strobe_group"}, group_EN, e.grp);
          chk({name, "_sweep_done"}, sweep_done, e.sd);
        end
      end else begin
        chk({name, "_sweep_done_idle"}, sweep_done, 0);
      end
      chk({name, "_run_done"}, run_done, (n == last));
      if (n < last) begin
        chk({name, "_group_EN"}, group_EN, ((n - 1) % SPER) / GPER);
        chk({name, "_busy"}, busy, 1);
        chk({name, "_group_valid"}, group_valid, 1);
      end else begin
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_group_valid_end"}, group_valid, 0);
        chk({name, "_group_EN_end"}, group_EN, 0);
        chk({name, "_sweep_count_end"}, sweep_count, s_exp);
      end
      if (n == 1) chk({name, "_sweep_count_clr"}, sweep_count, 0);
      stop  = (n == stop_at) || (idle_stop && n == last + 1);
      start = (n == poke_at);
      if (n == poke_at) num_sweeps = 16'd7;
      @(negedge clk);
    end
    stop  = 1'b0;
    start = 1'b0;
    chk({name, "_missing_strobes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    num_sweeps = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle");

    // single sweep
    run("one_sweep", 1, 0, 0, 1'b0);
    // three sweeps back to back
    run("three_sweeps", 3, 0, 0, 1'b0);
    // free-run, stop during group 1 of sweep 2
    run("free_stop", 0, 22, 0, 1'b0);
    // start and num_sweeps poked while busy, stray stop in IDLE afterwards
    run("busy_poke", 1, 0, 7, 1'b1);
    // stop in the same cycle as the final update
    run("stop_final", 1, SPER, 0, 1'b0);

    // reset while group 1 is settling
    @(negedge clk);
    start      = 1'b1;
    num_sweeps = 16'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("rst_pre_group", group_EN, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    start = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_beats_start");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_busy", busy, 0);
    run("after_rst", 1, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
